// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and round-robin search for rr_tenure_arbiter
//
// Contents:
//   DEF_*      default parameter values for the arbiter and its timers
//   HEADER_ID  flit_id value that marks a header flit
//   rr_next    first requester in round-robin order from a start index
package arb_pkg;

  localparam int unsigned DEF_NPORTS    = 5;
  localparam int unsigned DEF_FLIT_ID_W = 3;
  localparam int unsigned DEF_LEN_W     = 12;

  localparam logic [DEF_FLIT_ID_W-1:0] HEADER_ID = 3'b001;

  // The search works on a fixed-width request vector so one function serves
  // every port count up to MAX_PORTS.
  localparam int unsigned MAX_PORTS = 32;
  localparam int unsigned IDX_W     = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Examine 'span' channels starting at 'start', wrapping modulo 'n', and
  // return the first one with its request bit set. start < n and span <= n,
  // so a single conditional subtraction implements the wrap.
  function automatic rr_pick_t rr_next(input logic [MAX_PORTS-1:0] ereq,
                                       input logic [IDX_W-1:0]     start,
                                       input logic [IDX_W-1:0]     span,
                                       input logic [IDX_W-1:0]     n);
    rr_pick_t         pick;
    logic [IDX_W-1:0] idx;
    pick = '0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = start + IDX_W'(k);
      if (idx >= n) idx = idx - n;
      if (!pick.found && (IDX_W'(k) < span) && ereq[idx[4:0]]) begin
        pick.found = 1'b1;
        pick.idx   = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tenure_timer.sv
// rtl/tenure_timer.sv - per-channel tenure limit register and tenure counter
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   flit_id  flit type of this channel; HEADER_ID loads the limit
//   length   tenure limit captured on a header flit
//   run      channel is granted in the current cycle
//   restart  current tenure ends and a fresh one starts next cycle
//   timesup  tenure has used its limit (only asserted while run)
module tenure_timer #(
  parameter int unsigned           FLIT_ID_W = arb_pkg::DEF_FLIT_ID_W,
  parameter int unsigned           LEN_W     = arb_pkg::DEF_LEN_W,
  parameter logic [FLIT_ID_W-1:0]  HEADER_ID = FLIT_ID_W'(arb_pkg::HEADER_ID)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_ID_W-1:0] flit_id,
  input  logic [LEN_W-1:0]     length,
  input  logic                 run,
  input  logic                 restart,
  output logic                 timesup
);

  logic [LEN_W-1:0] limit;
  logic [LEN_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      limit <= '0;
      count <= '0;
    end else begin
      // Header capture is independent of grant; the compare below sees the
      // new limit only from the following cycle.
      if (flit_id == HEADER_ID) limit <= length;
      if (!run || restart) begin
        count <= '0;
      end else if (count != '1) begin
        // Saturate so a long tenure can never wrap back under the limit.
        count <= count + LEN_W'(1);
      end
    end
  end

  // >= rather than == so a limit lowered below the running count still ends
  // the tenure immediately.
  assign timesup = run && (count >= limit);

endmodule

// File: rtl/rr_tenure_arbiter.sv
// rtl/rr_tenure_arbiter.sv - round-robin NoC output-port arbiter with bounded tenure
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   flit_id   per-channel flit type, channel i at [i*FLIT_ID_W +: FLIT_ID_W]
//   length    per-channel tenure limit, captured on a header flit
//   req       per-channel request
//   enable    per-channel mask; a masked channel is never granted
//   grant     registered one-hot grant, all-zero when idle
//   grant_id  index of the granted channel, 0 when idle
//   expired   one-cycle pulse: tenure of channel i ended by timeout
module rr_tenure_arbiter #(
  parameter int unsigned          NPORTS    = arb_pkg::DEF_NPORTS,
  parameter int unsigned          FLIT_ID_W = arb_pkg::DEF_FLIT_ID_W,
  parameter int unsigned          LEN_W     = arb_pkg::DEF_LEN_W,
  parameter logic [FLIT_ID_W-1:0] HEADER_ID = FLIT_ID_W'(arb_pkg::HEADER_ID)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORTS*FLIT_ID_W-1:0] flit_id,
  input  logic [NPORTS*LEN_W-1:0]     length,
  input  logic [NPORTS-1:0]           req,
  input  logic [NPORTS-1:0]           enable,
  output logic [NPORTS-1:0]           grant,
  output logic [$clog2(NPORTS)-1:0]   grant_id,
  output logic [NPORTS-1:0]           expired
);

  import arb_pkg::*;

  localparam int unsigned IDW = $clog2(NPORTS);

  logic [NPORTS-1:0]    ereq;
  logic [NPORTS-1:0]    timesup;
  logic [NPORTS-1:0]    restart;
  logic [NPORTS-1:0]    nxt_grant;
  logic [NPORTS-1:0]    nxt_expired;
  logic [IDW-1:0]       nxt_id;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       nxt_ptr;
  logic [IDW-1:0]       hand_start;
  logic [MAX_PORTS-1:0] ereq_ext;
  logic                 hold;
  rr_pick_t             pick;

  // A dropped enable looks exactly like a dropped request.
  assign ereq = req & enable;

  for (genvar i = 0; i < NPORTS; i++) begin : g_timer
    tenure_timer #(
      .FLIT_ID_W (FLIT_ID_W),
      .LEN_W     (LEN_W),
      .HEADER_ID (HEADER_ID)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flit_id (flit_id[i*FLIT_ID_W +: FLIT_ID_W]),
      .length  (length[i*LEN_W +: LEN_W]),
      .run     (grant[i]),
      .restart (restart[i]),
      .timesup (timesup[i])
    );
  end

  // Hand-off search begins just past the current owner.
  assign hand_start = (grant_id == IDW'(NPORTS - 1)) ? '0 : grant_id + IDW'(1);

  always_comb begin
    ereq_ext              = '0;
    ereq_ext[NPORTS-1:0]  = ereq;
    pick                  = '0;
    hold                  = 1'b0;
    restart               = '0;
    nxt_expired           = '0;
    nxt_grant             = '0;
    nxt_id                = '0;
    nxt_ptr               = ptr;

    if (grant == '0) begin
      pick = rr_next(ereq_ext, IDX_W'(ptr), IDX_W'(NPORTS), IDX_W'(NPORTS));
    end else if (ereq[grant_id] && !timesup[grant_id]) begin
      hold = 1'b1;
    end else begin
      pick = rr_next(ereq_ext, IDX_W'(hand_start), IDX_W'(NPORTS - 1), IDX_W'(NPORTS));
      // Still requesting here means the tenure ended by timeout, whether it
      // is handed off or restarted.
      nxt_expired[grant_id] = ereq[grant_id] && timesup[grant_id];
      if (!pick.found && ereq[grant_id]) begin
        restart[grant_id] = 1'b1;
        hold              = 1'b1;
      end
    end

    if (hold) begin
      nxt_grant = grant;
      nxt_id    = grant_id;
    end else if (pick.found) begin
      nxt_id    = pick.idx[IDW-1:0];
      nxt_grant = NPORTS'(1) << nxt_id;
      nxt_ptr   = (nxt_id == IDW'(NPORTS - 1)) ? '0 : nxt_id + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      grant_id <= '0;
      expired  <= '0;
      ptr      <= '0;
    end else begin
      grant    <= nxt_grant;
      grant_id <= nxt_id;
      expired  <= nxt_expired;
      ptr      <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// tb/tb_rr_tenure_arbiter.sv - self-checking bench for rr_tenure_arbiter
module tb_rr_tenure_arbiter;

  localparam int N  = 5;
  localparam int FW = 3;
  localparam int LW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*FW-1:0] flit_id;
  logic [N*LW-1:0] length;
  logic [N-1:0]    req;
  logic [N-1:0]    enable;
  logic [N-1:0]    grant;
  logic [2:0]      grant_id;
  logic [N-1:0]    expired;

  rr_tenure_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .flit_id  (flit_id),
    .length   (length),
    .req      (req),
    .enable   (enable),
    .grant    (grant),
    .grant_id (grant_id),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 idle), age = completed cycles in the
  // current tenure, round-robin start, latched limits.
  int           m_owner;
  int           m_ptr;
  int           m_age;
  int           m_limit[N];
  logic [N-1:0] exp_grant;
  logic [N-1:0] exp_expired;
  int           exp_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_from(input int start, input int span, input logic [N-1:0] er);
    for (int k = 0; k < span; k++) begin
      if (er[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_age   = 0;
    for (int i = 0; i < N; i++) m_limit[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] er;
    int           nxt;
    bit           ts;
    er          = req & enable;
    exp_expired = '0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_owner < 0) begin
        nxt = pick_from(m_ptr, N, er);
        if (nxt >= 0) begin
          m_owner = nxt;
          m_age   = 0;
          m_ptr   = (nxt + 1) % N;
        end
      end else begin
        ts = (m_age >= m_limit[m_owner]);
        if (er[m_owner] && !ts) begin
          m_age++;
        end else begin
          exp_expired[m_owner] = er[m_owner] && ts;
          nxt = pick_from(m_owner + 1, N - 1, er);
          if (nxt >= 0) begin
            m_owner = nxt;
            m_age   = 0;
            m_ptr   = (nxt + 1) % N;
          end else if (er[m_owner]) begin
            m_age = 0;
          end else begin
            m_owner = -1;
          end
        end
      end
      // Limits update after the decision: the compare used the old value.
      for (int i = 0; i < N; i++) begin
        if (flit_id[i*FW +: FW] == 3'b001) m_limit[i] = int'(length[i*LW +: LW]);
      end
    end
    exp_grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
    exp_id    = (m_owner < 0) ? 0 : m_owner;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("grant", 32'(grant), 32'(exp_grant));
    check("grant_id", 32'(grant_id), 32'(exp_id));
    check("expired", 32'(expired), 32'(exp_expired));
  endtask

  task automatic set_hdr(input int ch, input int len);
    flit_id[ch*FW +: FW] = 3'b001;
    length[ch*LW +: LW]  = LW'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    flit_id = '0;
    length  = '0;
    req     = '0;
    enable  = '1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // Single channel, limit 3: four-cycle tenures with re-grant and expiry.
    set_hdr(0, 3);
    req = 5'b00001;
    tick();
    flit_id = '0;
    repeat (12) tick();

    // Channels 0 and 2 with limit 1 alternate in two-cycle tenures.
    do_reset();
    set_hdr(0, 1);
    set_hdr(2, 1);
    req = 5'b00101;
    tick();
    flit_id = '0;
    repeat (10) tick();

    // Make ptr = 3, then serve all five with one-cycle tenures back to back.
    do_reset();
    req = 5'b00100;
    tick();
    req = 5'b00000;
    tick();
    req = 5'b11111;
    tick();
    check("rr_order_0", 32'(grant_id), 32'd3);
    req = 5'b10111;
    tick();
    check("rr_order_1", 32'(grant_id), 32'd4);
    req = 5'b00111;
    tick();
    check("rr_order_2", 32'(grant_id), 32'd0);
    req = 5'b00110;
    tick();
    check("rr_order_3", 32'(grant_id), 32'd1);
    req = 5'b00100;
    tick();
    check("rr_order_4", 32'(grant_id), 32'd2);
    req = 5'b00000;
    tick();
    check("rr_idle", 32'(grant), 32'd0);

    // Limit lowered below the running count ends the tenure at once.
    do_reset();
    set_hdr(1, 100);
    req = 5'b00010;
    tick();
    flit_id = '0;
    repeat (6) tick();
    set_hdr(1, 2);
    tick();
    flit_id = '0;
    tick();
    check("lowered_limit_expired", 32'(expired), 32'h2);

    // Enable drop on the granted channel acts as a request drop.
    do_reset();
    set_hdr(2, 50);
    set_hdr(3, 50);
    req = 5'b01100;
    tick();
    flit_id = '0;
    tick();
    enable = 5'b11011;
    tick();
    check("enable_drop_grant", 32'(grant), 32'h8);
    check("enable_drop_expired", 32'(expired), 32'h0);
    enable = '1;

    // Reset mid-tenure on channel 4, then ptr restarts at 0.
    do_reset();
    req = 5'b10000;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    rst = 1'b0;
    req = 5'b10001;
    tick();
    check("post_rst_winner", 32'(grant), 32'h1);

    // Randomized traffic with headers, masks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      req    = N'($urandom);
      enable = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      for (int i = 0; i < N; i++) begin
        flit_id[i*FW +: FW] = FW'($urandom_range(0, 7));
        length[i*LW +: LW]  = LW'($urandom_range(0, 6));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
